// File: rtl/nand_alu_scheduler.sv
// Four requesters share one bit-serial ALU built only from 2-input NAND gates.
// A round-robin arbiter grants one operation, the engine walks it LSB first, the result is held until taken.
module nand_alu_scheduler #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req_valid,
    output logic [3:0]     req_ready,
    input  logic [11:0]    req_op,
    input  logic [4*W-1:0] req_a,
    input  logic [4*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [1:0]     rsp_id,
    output logic           rsp_err,
    output logic           busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    last_grant_q;
    logic [1:0]    id_q;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt_q;
    logic          rsp_valid_q;
    logic [W-1:0]  rsp_data_q;
    logic [1:0]    rsp_id_q;
    logic          rsp_err_q;
    logic          busy_q;

    logic          grant_found_s;
    logic [1:0]    grant_idx_s;
    logic [2:0]    sel_op_s;
    logic [W-1:0]  sel_a_s;
    logic [W-1:0]  sel_b_s;
    logic          bit_s;
    logic [W-1:0]  res_d;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Every operation is composed from nand2 only; reserved opcodes yield 0.
    function automatic logic nand_alu_bit(input logic [2:0] op, input logic x, input logic y);
        logic nxy;
        logic nxx;
        logic nyy;
        logic xo;
        nxy = nand2(x, y);
        nxx = nand2(x, x);
        nyy = nand2(y, y);
        xo  = nand2(nand2(x, nxy), nand2(y, nxy));
        case (op)
            3'b000:  return nand2(nxy, nxy);
            3'b001:  return nand2(nxx, nyy);
            3'b010:  return xo;
            3'b011:  return nand2(xo, xo);
            3'b100:  return nxx;
            3'b101:  return nxy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Scans offsets 4 down to 1 so the smallest offset from last_grant+1 wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (valid[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    // Arbitration and operand select for the current winner.
    always_comb begin
        {grant_found_s, grant_idx_s} = rr_pick(req_valid, last_grant_q);
        sel_op_s = req_op[3*int'(grant_idx_s) +: 3];
        sel_a_s  = req_a[W*int'(grant_idx_s) +: W];
        sel_b_s  = req_b[W*int'(grant_idx_s) +: W];
        if ((state_q == IDLE) && rst_n && grant_found_s) begin
            req_ready = 4'b0001 << grant_idx_s;
        end else begin
            req_ready = 4'b0000;
        end
    end

    // One result bit per EXEC cycle, merged into the partial result.
    always_comb begin
        bit_s        = nand_alu_bit(op_q, a_q[cnt_q], b_q[cnt_q]);
        res_d        = res_q;
        res_d[cnt_q] = bit_s;
    end

    // Scheduler FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            id_q         <= 2'd0;
            op_q         <= 3'd0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 2'd0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found_s) begin
                        op_q         <= sel_op_s;
                        a_q          <= sel_a_s;
                        b_q          <= sel_b_s;
                        id_q         <= grant_idx_s;
                        last_grant_q <= grant_idx_s;
                        cnt_q        <= '0;
                        res_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= res_d;
                    if (cnt_q == LAST_CNT) begin
                        rsp_data_q  <= res_d;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= is_reserved(op_q);
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_nand_alu_scheduler.sv
// Bench for nand_alu_scheduler: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_nand_alu_scheduler;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [11:0]    req_op;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_err;
    logic           busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    nand_alu_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: got no event required event within bound at %0t", name, $time);
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~a;
            3'd5:    return ~(a & b);
            default: return '0;
        endcase
    endfunction

    function automatic int rr_winner(input logic [3:0] v, input logic [1:0] last);
        for (int i = 1; i <= 4; i++) begin
            int j;
            j = (int'(last) + i) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Model: one operation in flight, its age in cycles since the handshake edge.
    bit           m_inflight = 1'b0;
    int           m_age = 0;
    logic [1:0]   m_last = 2'd3;
    logic [W-1:0] m_res = '0;
    logic [1:0]   m_id = 2'd0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_hold_data = '0;
    logic [1:0]   m_hold_id = 2'd0;
    logic         m_hold_err = 1'b0;

    always @(negedge clk) begin : compare
        logic [3:0] exp_ready;
        bit         exp_valid;
        int         g;
        logic [2:0] gop;
        if (!rst_n) begin
            m_inflight = 1'b0; m_last = 2'd3;
            m_hold_data = '0; m_hold_id = 2'd0; m_hold_err = 1'b0;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        end else begin
            g = rr_winner(req_valid, m_last);
            exp_ready = 4'b0000;
            if (!m_inflight && g >= 0) exp_ready = 4'b0001 << g;
            exp_valid = m_inflight && (m_age >= W + 1);
            if (exp_valid) begin
                m_hold_data = m_res; m_hold_id = m_id; m_hold_err = m_err;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(m_inflight));
            chk("rsp_data", 32'(rsp_data), 32'(m_hold_data));
            chk("rsp_id", 32'(rsp_id), 32'(m_hold_id));
            chk("rsp_err", 32'(rsp_err), 32'(m_hold_err));
            if (m_inflight) begin
                if (exp_valid && rsp_ready) m_inflight = 1'b0;
                else m_age++;
            end else if (g >= 0) begin
                gop = req_op[3*g +: 3];
                m_inflight = 1'b1;
                m_age = 1;
                m_last = 2'(g);
                m_id = 2'(g);
                m_err = (gop >= 3'd6);
                m_res = ref_fn(gop, req_a[W*g +: W], req_b[W*g +: W]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[3*id +: 3] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
    endtask

    // Returns true when the negedge sampling found cond within the bound.
    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] d, output logic [1:0] rid, output logic e, output bit ok);
        @(posedge clk);
        #1;
        set_req(id, op, a, b);
        req_valid = 4'b0001 << id;
        wait_ready(id, ok);
        if (!ok) begin
            timeout("send_handshake");
            req_valid = 4'b0000;
            return;
        end
        @(posedge clk);
        #1 req_valid = 4'b0000;
        @(negedge clk);
        lat = 1;
        ok = rsp_valid;
        if (!ok) begin
            int extra;
            wait_rsp(extra, ok);
            lat += extra;
        end
        if (!ok) begin
            timeout("send_response");
            return;
        end
        d = rsp_data; rid = rsp_id; e = rsp_err;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int           lat;
        logic [W-1:0] d;
        logic [1:0]   rid;
        logic         e;
        bit           ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   acc;
        int           rr_exp[5];

        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset_ready_literal", 32'(req_ready), 32'd0);
        chk("reset_busy_literal", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 3'b010, 8'hF0, 8'h3C, lat, d, rid, e, ok);
        if (ok) begin
            chk("xor_latency", 32'(lat), 32'd9);
            chk("xor_data", 32'(d), 32'hCC);
            chk("xor_id", 32'(rid), 32'd0);
            chk("xor_err", 32'(e), 32'd0);
        end

        for (int op = 0; op < 6; op++) begin
            a = W'($urandom); b = W'($urandom);
            send(op % 4, 3'(op), a, b, lat, d, rid, e, ok);
            if (ok) begin
                chk("legal_op_data", 32'(d), 32'(ref_fn(3'(op), a, b)));
                chk("legal_op_err", 32'(e), 32'd0);
            end
        end

        do_reset();
        send(2, 3'b111, W'($urandom), W'($urandom), lat, d, rid, e, ok);
        if (ok) begin
            chk("reserved_data", 32'(d), 32'h00);
            chk("reserved_err", 32'(e), 32'd1);
            chk("reserved_id", 32'(rid), 32'd2);
        end

        // Stall the consumer while requester 1 keeps a second request pending.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        set_req(1, 3'b100, 8'h5A, W'($urandom));
        req_valid = 4'b0010;
        wait_ready(1, ok);
        if (!ok) timeout("stall_handshake");
        wait_rsp(lat, ok);
        if (!ok) timeout("stall_response");
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'hA5);
            chk("stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_ready(1, ok);
        if (!ok) timeout("stall_regrant");
        @(posedge clk);
        #1 req_valid = 4'b0000;
        wait_rsp(lat, ok);
        if (!ok) timeout("stall_second_response");

        do_reset();
        rr_exp = '{0, 1, 2, 3, 0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) set_req(i, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        req_valid = 4'b1111;
        wait_ready(0, ok);
        if (!ok) timeout("rr_first_grant");
        chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_exp[0]));
        for (int k = 1; k < 5; k++) begin
            wait_rsp(lat, ok);
            if (!ok) begin timeout("rr_response"); break; end
            @(negedge clk);
            chk("rr_grant_after_consume", 32'(req_ready), 32'(4'b0001 << rr_exp[k]));
        end
        @(posedge clk);
        #1 req_valid = 4'b0000;
        wait_rsp(lat, ok);
        if (!ok) timeout("rr_last_response");

        // Abort requester 2 in its 4th EXEC cycle; the reset priority then favours requester 0.
        repeat (2) @(posedge clk);
        #1;
        set_req(2, 3'b001, W'($urandom), W'($urandom));
        req_valid = 4'b0100;
        wait_ready(2, ok);
        if (!ok) timeout("abort_handshake");
        @(posedge clk);
        #1 req_valid = 4'b1001;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_regrant", 32'(req_ready), 32'b0001);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 4'b0000;
        wait_rsp(lat, ok);
        if (!ok) timeout("abort_next_response");
        else chk("abort_next_id", 32'(rsp_id), 32'd0);

        // Random traffic: a requester holds its operation until accepted.
        acc = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (W + 5) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
